// File: rtl/spmi_tx_if.sv
// Frame request handshake between the command sequencer (master) and the
// SPMI transmitter (slave).
interface spmi_tx_if;
  logic [11:0] tx_data;
  logic        tx_cmd;
  logic        tx_ssc;
  logic        tx_last;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output tx_data, tx_cmd, tx_ssc, tx_last, tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data, tx_cmd, tx_ssc, tx_last, tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/spmi_tx.sv
// SPMI frame transmitter: drives SPMI clock/data from sysclk. Each frame can
// have an optional SSC and carries odd parity. The bus is parked after the last frame.
module spmi_tx #(
  parameter int CLKDIV   = 4,
  parameter int SSC_LOW  = 6,
  parameter int SSC_HIGH = 5
) (
  input  logic     sysclk,
  input  logic     reset_n,
  spmi_tx_if.slave bus,
  output logic     spmiclk,
  output logic     spmidat,
  output logic     spmidat_oe,
  output logic     busy,
  output logic     frame_done
);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] SSC_LO  = 4'd1;
  localparam logic [3:0] SSC_HI  = 4'd2;
  localparam logic [3:0] SSC_END = 4'd3;
  localparam logic [3:0] BIT_LO  = 4'd4;
  localparam logic [3:0] BIT_HI  = 4'd5;
  localparam logic [3:0] HOLD    = 4'd6;
  localparam logic [3:0] PARK_LO = 4'd7;
  localparam logic [3:0] PARK_HI = 4'd8;

  localparam logic [3:0] DIV_LOAD   = 4'(CLKDIV - 1);
  localparam logic [3:0] SSCL_LOAD  = 4'(SSC_LOW - 1);
  localparam logic [3:0] SSCH_LOAD  = 4'(SSC_HIGH - 1);

  logic [3:0]  state;
  logic [3:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [12:0] shreg;
  logic [12:0] load_vec;
  logic        last_q;
  logic        accept;
  logic        div_done;
  logic        par_cmd;
  logic        par_dat;

  // Frames are left-justified so the shifter always transmits from bit 12.
  always_comb begin
    par_cmd  = ~^bus.tx_data;
    par_dat  = ~^bus.tx_data[7:0];
    load_vec = bus.tx_cmd ? {bus.tx_data, par_cmd}
                          : {bus.tx_data[7:0], par_dat, 4'b0000};
  end

  assign accept   = bus.tx_valid && bus.tx_ready;
  assign div_done = (div_cnt == 4'd0);

  // Outputs are assigned together with the state change, so each state's
  // pad values appear on its first sysclk.
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      state        <= IDLE;
      div_cnt      <= 4'd0;
      bit_cnt      <= 4'd0;
      shreg        <= 13'd0;
      last_q       <= 1'b0;
      spmiclk      <= 1'b0;
      spmidat      <= 1'b0;
      spmidat_oe   <= 1'b0;
      bus.tx_ready <= 1'b1;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!div_done) div_cnt <= div_cnt - 4'd1;
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            shreg        <= load_vec;
            bit_cnt      <= bus.tx_cmd ? 4'd13 : 4'd9;
            last_q       <= bus.tx_last;
            bus.tx_ready <= 1'b0;
            busy         <= 1'b1;
            spmidat_oe   <= 1'b1;
            spmiclk      <= 1'b0;
            if (bus.tx_ssc) begin
              state   <= SSC_LO;
              div_cnt <= SSCL_LOAD;
              spmidat <= 1'b0;
            end else begin
              state   <= BIT_LO;
              div_cnt <= DIV_LOAD;
              spmidat <= load_vec[12];
            end
          end
        end
        SSC_LO: begin
          if (div_done) begin
            state   <= SSC_HI;
            div_cnt <= SSCH_LOAD;
            spmidat <= 1'b1;
          end
        end
        SSC_HI: begin
          if (div_done) begin
            state   <= SSC_END;
            div_cnt <= DIV_LOAD;
            spmidat <= 1'b0;
          end
        end
        SSC_END: begin
          if (div_done) begin
            state   <= BIT_LO;
            div_cnt <= DIV_LOAD;
            spmidat <= shreg[12];
          end
        end
        BIT_LO: begin
          if (div_done) begin
            state   <= BIT_HI;
            div_cnt <= DIV_LOAD;
            spmiclk <= 1'b1;
          end
        end
        BIT_HI: begin
          // frame_done must land on the final high cycle, one ahead of the exit.
          if (div_cnt == 4'd1 && bit_cnt == 4'd1) frame_done <= 1'b1;
          if (div_done) begin
            spmiclk <= 1'b0;
            if (bit_cnt == 4'd1) begin
              spmidat <= 1'b0;
              if (last_q) begin
                state   <= PARK_LO;
                div_cnt <= DIV_LOAD;
              end else begin
                state        <= HOLD;
                bus.tx_ready <= 1'b1;
              end
            end else begin
              state   <= BIT_LO;
              div_cnt <= DIV_LOAD;
              shreg   <= {shreg[11:0], 1'b0};
              spmidat <= shreg[11];
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
        end
        PARK_LO: begin
          if (div_done) begin
            state      <= PARK_HI;
            div_cnt    <= DIV_LOAD;
            spmiclk    <= 1'b1;
            spmidat_oe <= 1'b0;
          end
        end
        PARK_HI: begin
          if (div_done) begin
            state        <= IDLE;
            spmiclk      <= 1'b0;
            busy         <= 1'b0;
            bus.tx_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spmi_tx.sv
// Self-checking bench for spmi_tx: a scoreboard of expected bits is filled at
// each accept and drained on every data-carrying spmiclk rising edge.
module tb_spmi_tx;
  localparam int CLKDIV   = 4;
  localparam int SSC_LOW  = 6;
  localparam int SSC_HIGH = 5;

  typedef struct {
    logic [11:0] data;
    logic        cmd;
    logic        ssc;
    logic        last;
    logic        par;
  } vec_t;

  logic sysclk  = 1'b0;
  logic reset_n = 1'b0;
  logic spmiclk, spmidat, spmidat_oe, busy, frame_done;

  spmi_tx_if bus ();

  spmi_tx #(
    .CLKDIV  (CLKDIV),
    .SSC_LOW (SSC_LOW),
    .SSC_HIGH(SSC_HIGH)
  ) dut (
    .sysclk    (sysclk),
    .reset_n   (reset_n),
    .bus       (bus),
    .spmiclk   (spmiclk),
    .spmidat   (spmidat),
    .spmidat_oe(spmidat_oe),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 sysclk = ~sysclk;

  int   tests       = 0;
  int   fails       = 0;
  int   cyc         = 0;
  int   rise_cnt    = 0;
  int   done_cycles = 0;
  int   frames_exp  = 0;
  int   acc_cyc     = 0;
  logic prev_clk    = 1'b0;
  logic exp_q[$];
  vec_t tbl[6];

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void pushFrame(input vec_t v);
    for (int i = (v.cmd ? 11 : 7); i >= 0; i--) exp_q.push_back(v.data[i]);
    exp_q.push_back(v.par);
  endfunction

  // Data bits are the rising spmiclk edges seen while the pad is driven.
  always @(negedge sysclk) begin
    if (spmiclk && !prev_clk) begin
      rise_cnt <= rise_cnt + 1;
      if (spmidat_oe) begin
        if (exp_q.size() == 0) checkOutput("extra_bit", 32'(spmidat), 32'hDEAD);
        else checkOutput("data_bit", 32'(spmidat), 32'(exp_q.pop_front()));
      end
    end
    prev_clk <= spmiclk;
    if (frame_done) done_cycles <= done_cycles + 1;
  end

  task automatic applyStimulus(input vec_t v, input bit keep_valid, input bit jitter);
    int waited = 0;
    bit got = 0;
    while (!got && waited < 400) begin
      @(negedge sysclk);
      if (bus.tx_ready) begin
        bus.tx_data  = v.data;
        bus.tx_cmd   = v.cmd;
        bus.tx_ssc   = v.ssc;
        bus.tx_last  = v.last;
        bus.tx_valid = 1'b1;
        got = 1;
      end else begin
        if (jitter) begin
          bus.tx_data  = 12'($urandom);
          bus.tx_valid = 1'b1;
        end
        waited++;
      end
    end
    if (!got) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      return;
    end
    pushFrame(v);
    frames_exp++;
    @(posedge sysclk);
    #1;
    acc_cyc = cyc;
    if (!keep_valid) bus.tx_valid = 1'b0;
  endtask

  task automatic waitIdle(output int idle_cyc);
    idle_cyc = -1;
    for (int k = 0; k < 600; k++) begin
      if (!busy) begin
        idle_cyc = cyc;
        break;
      end
      @(posedge sysclk);
      #1;
    end
    if (idle_cyc < 0) checkOutput("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkIdle(input string pfx);
    checkOutput({pfx, "_clk"},   32'(spmiclk),      32'd0);
    checkOutput({pfx, "_dat"},   32'(spmidat),      32'd0);
    checkOutput({pfx, "_oe"},    32'(spmidat_oe),   32'd0);
    checkOutput({pfx, "_ready"}, 32'(bus.tx_ready), 32'd1);
    checkOutput({pfx, "_busy"},  32'(busy),         32'd0);
  endtask

  initial begin
    vec_t v;
    int   t0, ic, errs, park_hi, r0, n;

    tbl[0] = '{12'h000, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{12'hFFF, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{12'h007, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{12'hF80, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{12'h800, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{12'h0C5, 1'b0, 1'b0, 1'b1, 1'b1};

    bus.tx_data  = 12'h000;
    bus.tx_cmd   = 1'b0;
    bus.tx_ssc   = 1'b0;
    bus.tx_last  = 1'b0;
    bus.tx_valid = 1'b0;

    repeat (3) @(posedge sysclk);
    #1;
    checkIdle("reset");
    checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
    @(negedge sysclk);
    reset_n = 1'b1;

    // SSC + data frame + park, with exact waveform timing.
    v = '{12'h0A5, 1'b0, 1'b1, 1'b1, 1'b1};
    applyStimulus(v, 1'b0, 1'b0);
    t0 = acc_cyc;
    errs = 0;
    park_hi = 0;
    for (int i = 0; i < 300; i++) begin
      if (!busy) break;
      if (i < 15) begin
        if (spmiclk !== 1'b0 || spmidat_oe !== 1'b1 ||
            spmidat !== ((i >= 6 && i < 11) ? 1'b1 : 1'b0)) errs++;
      end
      if (spmiclk && !spmidat_oe) park_hi++;
      @(posedge sysclk);
      #1;
    end
    checkOutput("t1_ssc_shape", 32'(errs), 32'd0);
    checkOutput("t1_busy_cycles", 32'(cyc - t0), 32'd95);
    checkOutput("t1_park_hi", 32'(park_hi), 32'(CLKDIV));
    checkIdle("t1_end");
    checkOutput("t1_frames", 32'(done_cycles), 32'(frames_exp));

    // Command frame ending in HOLD.
    v = '{12'h123, 1'b1, 1'b1, 1'b0, 1'b1};
    applyStimulus(v, 1'b0, 1'b0);
    t0 = acc_cyc;
    n = -1;
    for (int i = 0; i < 300; i++) begin
      if (bus.tx_ready) begin
        n = cyc - t0;
        break;
      end
      @(posedge sysclk);
      #1;
    end
    checkOutput("t2_cycles_to_hold", 32'(n), 32'd119);
    checkOutput("t2_hold_clk", 32'(spmiclk), 32'd0);
    checkOutput("t2_hold_oe", 32'(spmidat_oe), 32'd1);
    checkOutput("t2_hold_busy", 32'(busy), 32'd1);
    checkOutput("t2_frames", 32'(done_cycles), 32'(frames_exp));

    // Back-to-back frames from HOLD with valid held high.
    r0 = rise_cnt;
    v = '{12'h001, 1'b0, 1'b0, 1'b0, 1'b0};
    applyStimulus(v, 1'b1, 1'b0);
    t0 = acc_cyc;
    v = '{12'h0FF, 1'b0, 1'b0, 1'b1, 1'b1};
    applyStimulus(v, 1'b0, 1'b0);
    waitIdle(ic);
    checkOutput("t3_busy_cycles", 32'(ic - t0), 32'd153);
    checkOutput("t3_clock_edges", 32'(rise_cnt - r0), 32'd19);
    checkIdle("t3_end");
    checkOutput("t3_frames", 32'(done_cycles), 32'(frames_exp));

    // Valid held with data changing while busy: only accept-time values go out.
    v = '{12'h0C3, 1'b0, 1'b0, 1'b0, 1'b1};
    applyStimulus(v, 1'b1, 1'b1);
    v = '{12'h03C, 1'b0, 1'b1, 1'b1, 1'b1};
    applyStimulus(v, 1'b0, 1'b1);
    waitIdle(ic);
    checkOutput("t4_frames", 32'(done_cycles), 32'(frames_exp));
    checkOutput("t4_queue", 32'(exp_q.size()), 32'd0);

    // Reset pulse during the high phase of bit index 4 of a command frame.
    v = '{12'hABC, 1'b1, 1'b0, 1'b1, 1'b0};
    applyStimulus(v, 1'b0, 1'b0);
    repeat (36) @(posedge sysclk);
    @(negedge sysclk);
    reset_n = 1'b0;
    @(posedge sysclk);
    #1;
    checkIdle("t5_reset");
    checkOutput("t5_frame_done", 32'(frame_done), 32'd0);
    checkOutput("t5_bits_left", 32'(exp_q.size()), 32'd8);
    exp_q.delete();
    frames_exp--;
    @(negedge sysclk);
    reset_n = 1'b1;

    // Table of frames; each chains through HOLD until a last=1 entry.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i], 1'b0, 1'b0);
      if (tbl[i].last) begin
        waitIdle(ic);
        checkIdle($sformatf("tbl%0d_end", i));
      end
    end
    repeat (4) @(posedge sysclk);
    #1;
    checkOutput("frame_done_total", 32'(done_cycles), 32'(frames_exp));
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
